// File: rtl/sdf_bfly_stage_if.sv
// Streaming interface of the SDF butterfly stage: input samples, ROM phase and twiddle
// travel towards the stage; the butterfly/rotation stream comes back.
interface sdf_bfly_stage_if #(
    parameter int unsigned WIDTH = 24
);
    logic                    in_valid;
    logic signed [WIDTH-1:0] din_r;
    logic signed [WIDTH-1:0] din_i;
    logic [1:0]              state;
    logic signed [WIDTH-1:0] w_r;
    logic signed [WIDTH-1:0] w_i;
    logic                    out_valid;
    logic signed [WIDTH-1:0] dout_r;
    logic signed [WIDTH-1:0] dout_i;

    // Upstream side: ROM/sample source plus the consumer of the output stream.
    modport master (
        output in_valid, din_r, din_i, state, w_r, w_i,
        input  out_valid, dout_r, dout_i
    );

    // The butterfly stage itself.
    modport slave (
        input  in_valid, din_r, din_i, state, w_r, w_i,
        output out_valid, dout_r, dout_i
    );
endinterface

// File: rtl/sdf_bfly_stage.sv
// Radix-2 single-path delay-feedback butterfly stage. A DEPTH-entry complex delay line
// pairs x[n] with x[n+DEPTH]; the stage emits butterfly sums while storing differences,
// then emits the stored differences rotated by the twiddle supplied by the ROM.
module sdf_bfly_stage #(
    parameter int unsigned WIDTH      = 24,
    parameter int unsigned FRAC       = 8,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned BFLY_SHIFT = 0
) (
    input logic             clk,
    input logic             rst_n,
    sdf_bfly_stage_if.slave bus
);

    typedef enum logic [1:0] {
        PhFill = 2'd0,
        PhBfly = 2'd1,
        PhRot  = 2'd2,
        PhIdle = 2'd3
    } phase_e;

    // Delay line: index 0 is the head (oldest), DEPTH-1 the tail.
    logic signed [WIDTH-1:0] r_dly_r [DEPTH];
    logic signed [WIDTH-1:0] r_dly_i [DEPTH];

    logic                    r_out_valid;
    logic signed [WIDTH-1:0] r_dout_r;
    logic signed [WIDTH-1:0] r_dout_i;

    phase_e                  w_phase;
    logic                    w_step;
    logic signed [WIDTH-1:0] w_head_r;
    logic signed [WIDTH-1:0] w_head_i;

    // Butterfly datapath, one bit wider than the samples so a+b cannot overflow before
    // the optional scaling shift.
    logic signed [WIDTH:0]   w_a_r_x;
    logic signed [WIDTH:0]   w_a_i_x;
    logic signed [WIDTH:0]   w_b_r_x;
    logic signed [WIDTH:0]   w_b_i_x;
    logic signed [WIDTH:0]   w_sum_r_sh;
    logic signed [WIDTH:0]   w_sum_i_sh;
    logic signed [WIDTH:0]   w_diff_r_sh;
    logic signed [WIDTH:0]   w_diff_i_sh;

    // Rotation datapath: full-precision products, one extra bit for the add/sub.
    logic signed [2*WIDTH-1:0] w_hr_x;
    logic signed [2*WIDTH-1:0] w_hi_x;
    logic signed [2*WIDTH-1:0] w_wr_x;
    logic signed [2*WIDTH-1:0] w_wi_x;
    logic signed [2*WIDTH-1:0] w_p_rr;
    logic signed [2*WIDTH-1:0] w_p_ii;
    logic signed [2*WIDTH-1:0] w_p_ri;
    logic signed [2*WIDTH-1:0] w_p_ir;
    logic signed [2*WIDTH:0]   w_re_full;
    logic signed [2*WIDTH:0]   w_im_full;
    logic signed [2*WIDTH:0]   w_re_sh;
    logic signed [2*WIDTH:0]   w_im_sh;

    logic                    w_out_en;
    logic signed [WIDTH-1:0] w_out_r;
    logic signed [WIDTH-1:0] w_out_i;
    logic signed [WIDTH-1:0] w_tail_r;
    logic signed [WIDTH-1:0] w_tail_i;
    logic                    w_unused;

    function automatic logic signed [2*WIDTH:0] sext_p(input logic signed [2*WIDTH-1:0] p);
        return {p[2*WIDTH-1], p};
    endfunction

    assign w_phase  = phase_e'(bus.state);
    assign w_step   = bus.in_valid && (w_phase != PhIdle);
    assign w_head_r = r_dly_r[0];
    assign w_head_i = r_dly_i[0];

    // Sum/difference of head (a) and incoming sample (b), wrapped after scaling.
    always_comb begin
        w_a_r_x     = {w_head_r[WIDTH-1], w_head_r};
        w_a_i_x     = {w_head_i[WIDTH-1], w_head_i};
        w_b_r_x     = {bus.din_r[WIDTH-1], bus.din_r};
        w_b_i_x     = {bus.din_i[WIDTH-1], bus.din_i};
        w_sum_r_sh  = (w_a_r_x + w_b_r_x) >>> BFLY_SHIFT;
        w_sum_i_sh  = (w_a_i_x + w_b_i_x) >>> BFLY_SHIFT;
        w_diff_r_sh = (w_a_r_x - w_b_r_x) >>> BFLY_SHIFT;
        w_diff_i_sh = (w_a_i_x - w_b_i_x) >>> BFLY_SHIFT;
    end

    // Complex rotation of the head by the twiddle; shift truncates toward -inf.
    always_comb begin
        w_hr_x    = {{WIDTH{w_head_r[WIDTH-1]}}, w_head_r};
        w_hi_x    = {{WIDTH{w_head_i[WIDTH-1]}}, w_head_i};
        w_wr_x    = {{WIDTH{bus.w_r[WIDTH-1]}}, bus.w_r};
        w_wi_x    = {{WIDTH{bus.w_i[WIDTH-1]}}, bus.w_i};
        w_p_rr    = w_hr_x * w_wr_x;
        w_p_ii    = w_hi_x * w_wi_x;
        w_p_ri    = w_hr_x * w_wi_x;
        w_p_ir    = w_hi_x * w_wr_x;
        w_re_full = sext_p(w_p_rr) - sext_p(w_p_ii);
        w_im_full = sext_p(w_p_ri) + sext_p(w_p_ir);
        w_re_sh   = w_re_full >>> FRAC;
        w_im_sh   = w_im_full >>> FRAC;
    end

    // Per-step selection of the output sample and the value written at the tail.
    always_comb begin
        w_out_en = 1'b0;
        w_out_r  = r_dout_r;
        w_out_i  = r_dout_i;
        w_tail_r = bus.din_r;
        w_tail_i = bus.din_i;
        if (w_step) begin
            unique case (w_phase)
                PhFill: begin
                    w_tail_r = bus.din_r;
                    w_tail_i = bus.din_i;
                end
                PhBfly: begin
                    w_out_en = 1'b1;
                    w_out_r  = w_sum_r_sh[WIDTH-1:0];
                    w_out_i  = w_sum_i_sh[WIDTH-1:0];
                    w_tail_r = w_diff_r_sh[WIDTH-1:0];
                    w_tail_i = w_diff_i_sh[WIDTH-1:0];
                end
                PhRot: begin
                    // Tail takes the first half of the next frame while differences drain.
                    w_out_en = 1'b1;
                    w_out_r  = w_re_sh[WIDTH-1:0];
                    w_out_i  = w_im_sh[WIDTH-1:0];
                    w_tail_r = bus.din_r;
                    w_tail_i = bus.din_i;
                end
                PhIdle: begin
                    w_out_en = 1'b0;
                end
                default: begin
                    w_out_en = 1'b0;
                end
            endcase
        end
    end

    // Bits dropped by the wrap/truncation are intentionally discarded.
    assign w_unused = ^{w_sum_r_sh, w_sum_i_sh, w_diff_r_sh, w_diff_i_sh, w_re_sh, w_im_sh};

    // Delay line shifts one place per step; output register holds when no step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                r_dly_r[k] <= '0;
                r_dly_i[k] <= '0;
            end
            r_out_valid <= 1'b0;
            r_dout_r    <= '0;
            r_dout_i    <= '0;
        end else begin
            r_out_valid <= w_out_en;
            if (w_step) begin
                for (int k = 0; k < int'(DEPTH) - 1; k++) begin
                    r_dly_r[k] <= r_dly_r[k+1];
                    r_dly_i[k] <= r_dly_i[k+1];
                end
                r_dly_r[DEPTH-1] <= w_tail_r;
                r_dly_i[DEPTH-1] <= w_tail_i;
            end
            if (w_out_en) begin
                r_dout_r <= w_out_r;
                r_dout_i <= w_out_i;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.dout_r    = r_dout_r;
    assign bus.dout_i    = r_dout_i;

endmodule

// File: tb/tb_sdf_bfly_stage.sv
// Bench for sdf_bfly_stage: two instances (BFLY_SHIFT 0 and 1) driven in lockstep and
// compared against a queue-based reference model, plus directed known-answer checks.
module tb_sdf_bfly_stage;

    localparam int W = 24;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    sdf_bfly_stage_if #(.WIDTH(W)) bus0 ();
    sdf_bfly_stage_if #(.WIDTH(W)) bus1 ();

    sdf_bfly_stage #(.WIDTH(W), .FRAC(8), .DEPTH(4), .BFLY_SHIFT(0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    sdf_bfly_stage #(.WIDTH(W), .FRAC(8), .DEPTH(4), .BFLY_SHIFT(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    // One model entry holds the delay-line contents of both instances.
    typedef struct {
        longint r0;
        longint i0;
        longint r1;
        longint i1;
    } ent_t;

    ent_t   mq[$];
    int     n_checks = 0;
    int     n_fail   = 0;
    logic   exp_v;
    longint exp_r [2];
    longint exp_i [2];

    task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic longint wrap24(input longint v);
        logic signed [W-1:0] t;
        t = v[W-1:0];
        return longint'(t);
    endfunction

    task automatic model_reset();
        ent_t z;
        z = '{r0: 0, i0: 0, r1: 0, i1: 0};
        mq.delete();
        for (int k = 0; k < 4; k++) mq.push_back(z);
        exp_v = 1'b0;
        for (int k = 0; k < 2; k++) begin
            exp_r[k] = 0;
            exp_i[k] = 0;
        end
    endtask

    // Behavioural step: pop oldest, compute output, push new tail.
    task automatic model_step(input logic v, input int st, input longint dr, input longint di,
                              input longint wr, input longint wi);
        ent_t   e;
        ent_t   t;
        longint ar [2];
        longint ai [2];
        longint tr [2];
        longint ti [2];
        exp_v = 1'b0;
        if (v && st != 3) begin
            e = mq.pop_front();
            ar[0] = e.r0; ai[0] = e.i0; ar[1] = e.r1; ai[1] = e.i1;
            for (int k = 0; k < 2; k++) begin
                tr[k] = dr;
                ti[k] = di;
                if (st == 1) begin
                    exp_r[k] = wrap24((ar[k] + dr) >>> k);
                    exp_i[k] = wrap24((ai[k] + di) >>> k);
                    tr[k]    = wrap24((ar[k] - dr) >>> k);
                    ti[k]    = wrap24((ai[k] - di) >>> k);
                end else if (st == 2) begin
                    exp_r[k] = wrap24((ar[k] * wr - ai[k] * wi) >>> 8);
                    exp_i[k] = wrap24((ar[k] * wi + ai[k] * wr) >>> 8);
                end
            end
            exp_v = (st != 0);
            t = '{r0: tr[0], i0: ti[0], r1: tr[1], i1: ti[1]};
            mq.push_back(t);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] st, input logic signed [W-1:0] dr,
                         input logic signed [W-1:0] di, input logic signed [W-1:0] wr,
                         input logic signed [W-1:0] wi);
        bus0.in_valid = v;  bus1.in_valid = v;
        bus0.state    = st; bus1.state    = st;
        bus0.din_r    = dr; bus1.din_r    = dr;
        bus0.din_i    = di; bus1.din_i    = di;
        bus0.w_r      = wr; bus1.w_r      = wr;
        bus0.w_i      = wi; bus1.w_i      = wi;
    endtask

    // One clock: apply inputs at negedge, check both instances #1 after posedge.
    task automatic step(input logic v, input logic [1:0] st, input logic signed [W-1:0] dr,
                        input logic signed [W-1:0] di, input logic signed [W-1:0] wr,
                        input logic signed [W-1:0] wi);
        @(negedge clk);
        drive(v, st, dr, di, wr, wi);
        model_step(v, int'(st), longint'(dr), longint'(di), longint'(wr), longint'(wi));
        @(posedge clk);
        #1;
        check_eq("m_v0", W'(bus0.out_valid), W'(exp_v));
        check_eq("m_v1", W'(bus1.out_valid), W'(exp_v));
        check_eq("m_r0", bus0.dout_r, exp_r[0][W-1:0]);
        check_eq("m_i0", bus0.dout_i, exp_i[0][W-1:0]);
        check_eq("m_r1", bus1.dout_r, exp_r[1][W-1:0]);
        check_eq("m_i1", bus1.dout_i, exp_i[1][W-1:0]);
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_v0"}, W'(bus0.out_valid), '0);
        check_eq({tag, "_r0"}, bus0.dout_r, '0);
        check_eq({tag, "_i0"}, bus0.dout_i, '0);
        check_eq({tag, "_v1"}, W'(bus1.out_valid), '0);
        check_eq({tag, "_r1"}, bus1.dout_r, '0);
    endtask

    task automatic fill_bfly(input logic [1:0] st, input logic signed [W-1:0] base);
        for (int k = 0; k < 4; k++) begin
            step(1'b1, st, base + W'(k * 256), '0, '0, '0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 2'd3, '0, '0, '0, '0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // T1: traffic, then asynchronous reset mid-stream.
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 2'd1, W'($urandom), W'($urandom), '0, '0);
        end
        @(negedge clk);
        drive(1'b0, 2'd1, '0, '0, '0, '0);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("arst");
        model_reset();
        @(posedge clk);
        #1;
        check_zero("arst_edge");
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 2'd1, 24'h000123, 24'h000045, '0, '0);
        check_eq("t1_sum_r", bus0.dout_r, 24'h000123);
        check_eq("t1_sum_i", bus0.dout_i, 24'h000045);

        // T2: fill then butterfly.
        fill_bfly(2'd0, 24'h000100);
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 2'd1, 24'h000500 + W'(k * 256), '0, '0, '0);
            check_eq("t2_sum_r", bus0.dout_r, 24'h000600 + W'(k * 512));
            check_eq("t2_sum_i", bus0.dout_i, 24'h000000);
        end

        // T3: rotate the stored differences.
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 2'd2, '0, '0, 24'h0000B5, 24'h0000B5);
            check_eq("t3_rot_r", bus0.dout_r, 24'hFFFD2C);
            check_eq("t3_rot_i", bus0.dout_i, 24'hFFFD2C);
        end
        fill_bfly(2'd0, 24'h000100);
        fill_bfly(2'd1, 24'h000500);
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 2'd2, '0, '0, 24'h000000, 24'h000100);
            check_eq("t3_j_r", bus0.dout_r, 24'h000000);
            check_eq("t3_j_i", bus0.dout_i, 24'hFFFC00);
        end

        // T4: stall in the butterfly phase.
        for (int k = 0; k < 4; k++) step(1'b1, 2'd0, W'($urandom), W'($urandom), '0, '0);
        for (int k = 0; k < 2; k++) step(1'b1, 2'd1, W'($urandom), W'($urandom), '0, '0);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 2'd1, W'($urandom), W'($urandom), '0, '0);
            check_eq("t4_stall_v", W'(bus0.out_valid), '0);
        end
        for (int k = 0; k < 2; k++) step(1'b1, 2'd1, W'($urandom), W'($urandom), '0, '0);

        // T5: overflow wrap and /2 scaling.
        for (int k = 0; k < 4; k++) step(1'b1, 2'd0, 24'h7FFF00, '0, '0, '0);
        step(1'b1, 2'd1, 24'h000100, '0, '0, '0);
        check_eq("t5_wrap", bus0.dout_r, 24'h800000);
        check_eq("t5_half", bus1.dout_r, 24'h400000);

        // T6: idle with in_valid high.
        for (int k = 0; k < 4; k++) step(1'b1, 2'd0, W'($urandom), W'($urandom), '0, '0);
        step(1'b1, 2'd1, W'($urandom), W'($urandom), '0, '0);
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 2'd3, W'($urandom), W'($urandom), '0, '0);
            check_eq("t6_idle_v", W'(bus0.out_valid), '0);
        end
        for (int k = 0; k < 3; k++) step(1'b1, 2'd1, W'($urandom), W'($urandom), '0, '0);

        // Random traffic: any phase, occasional gaps, full-range data and twiddles.
        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(0, 9) != 0), 2'($urandom_range(0, 3)), W'($urandom),
                 W'($urandom), W'($urandom), W'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
